// File: rtl/matmul_operand_feeder_pkg.sv
// rtl/matmul_operand_feeder_pkg.sv - shared sizes, FSM states and dimension check for the operand feeder
package matmul_operand_feeder_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int BUS_WIDTH  = 64;
   localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
   localparam int DIM_W      = $clog2(MAX_DIM + 1);
   localparam int CNT_W      = DIM_W + 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   function automatic logic dim_ok(input logic [DIM_W-1:0] d);
      return (d != '0) && (d <= DIM_W'(MAX_DIM));
   endfunction

endpackage

// File: rtl/matmul_skew_lane.sv
// rtl/matmul_skew_lane.sv - one skewed edge lane: picks element t-lane of its vector and registers it
module matmul_skew_lane #(
   parameter int DW  = 32,
   parameter int NUM = 2,
   parameter int CW  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              active,
   input  logic [NUM*DW-1:0] vec,
   input  logic [CW-1:0]     lane,
   input  logic [CW-1:0]     t,
   input  logic [CW-1:0]     k,
   output logic [DW-1:0]     data,
   output logic              valid
);

   logic [CW-1:0] off;
   logic          hit;
   logic [DW-1:0] sel;

   // off wraps when t < lane; the t >= lane term masks that case
   always_comb begin
      off = t - lane;
      hit = active && (t >= lane) && (off < k);
      sel = '0;
      for (int e = 0; e < NUM; e++) begin
         if (off == CW'(e)) sel = vec[e*DW +: DW];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data  <= '0;
         valid <= 1'b0;
      end else if (en) begin
         valid <= hit;
         data  <= hit ? sel : '0;
      end
   end

endmodule

// File: rtl/matmul_operand_feeder.sv
// rtl/matmul_operand_feeder.sv - captures A/B operands and streams them skewed into the PE array
module matmul_operand_feeder
   import matmul_operand_feeder_pkg::*;
(
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          start_i,
   input  logic                          stall_i,
   input  logic [DIM_W-1:0]              dim_n_i,
   input  logic [DIM_W-1:0]              dim_k_i,
   input  logic [DIM_W-1:0]              dim_m_i,
   input  logic [MAX_DIM*BUS_WIDTH-1:0]  a_rows_i,
   input  logic [MAX_DIM*BUS_WIDTH-1:0]  b_rows_i,
   output logic [MAX_DIM*DATA_WIDTH-1:0] a_data_o,
   output logic [MAX_DIM-1:0]            a_valid_o,
   output logic [MAX_DIM*DATA_WIDTH-1:0] b_data_o,
   output logic [MAX_DIM-1:0]            b_valid_o,
   output logic                          clear_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          err_o
);

   localparam int ROW_W = MAX_DIM * DATA_WIDTH;
   localparam logic [CNT_W-1:0] DRAIN_LEN = CNT_W'(2 * (MAX_DIM - 1));

   state_e                       state, nxt_state;
   logic [CNT_W-1:0]             t_q, t_n, d_q, d_n;
   logic [CNT_W-1:0]             stream_len;
   logic [DIM_W-1:0]             n_q, k_q, m_q;
   logic [MAX_DIM*BUS_WIDTH-1:0] a_q, b_q;
   logic                         capture, err_n;
   logic [MAX_DIM-1:0][ROW_W-1:0] b_col;

   assign stream_len = CNT_W'(k_q) + CNT_W'(MAX_DIM - 1);

   always_comb begin
      nxt_state = state;
      t_n       = t_q;
      d_n       = d_q;
      capture   = 1'b0;
      err_n     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_i) begin
               if (dim_ok(dim_n_i) && dim_ok(dim_k_i) && dim_ok(dim_m_i)) begin
                  capture   = 1'b1;
                  nxt_state = ST_CLEAR;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         ST_CLEAR: begin
            nxt_state = ST_STREAM;
            t_n       = '0;
         end
         ST_STREAM: begin
            if (t_q == stream_len - CNT_W'(1)) begin
               d_n       = '0;
               nxt_state = (DRAIN_LEN == '0) ? ST_DONE : ST_DRAIN;
            end else begin
               t_n = t_q + CNT_W'(1);
            end
         end
         ST_DRAIN: begin
            if (d_q == DRAIN_LEN - CNT_W'(1)) nxt_state = ST_DONE;
            else d_n = d_q + CNT_W'(1);
         end
         ST_DONE:  nxt_state = ST_IDLE;
         default:  nxt_state = ST_IDLE;
      endcase
   end

   // control outputs decode the next state so they line up with the state they describe
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= ST_IDLE;
         t_q     <= '0;
         d_q     <= '0;
         n_q     <= '0;
         k_q     <= '0;
         m_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         clear_o <= 1'b0;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
         err_o   <= 1'b0;
      end else if (!stall_i) begin
         state   <= nxt_state;
         t_q     <= t_n;
         d_q     <= d_n;
         clear_o <= (nxt_state == ST_CLEAR);
         busy_o  <= (nxt_state != ST_IDLE);
         done_o  <= (nxt_state == ST_DONE);
         err_o   <= err_n;
         if (capture) begin
            n_q <= dim_n_i;
            k_q <= dim_k_i;
            m_q <= dim_m_i;
            a_q <= a_rows_i;
            b_q <= b_rows_i;
         end
      end
   end

   always_comb begin
      b_col = '0;
      for (int j = 0; j < MAX_DIM; j++) begin
         for (int r = 0; r < MAX_DIM; r++) begin
            b_col[j][r*DATA_WIDTH +: DATA_WIDTH] = b_q[r*BUS_WIDTH + j*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   for (genvar i = 0; i < MAX_DIM; i++) begin : g_lane
      matmul_skew_lane #(.DW(DATA_WIDTH), .NUM(MAX_DIM), .CW(CNT_W)) u_a_lane (
         .clk    (clk_i),
         .rst_n  (rst_ni),
         .en     (!stall_i),
         .active ((nxt_state == ST_STREAM) && (DIM_W'(i) < n_q)),
         .vec    (a_q[i*BUS_WIDTH +: ROW_W]),
         .lane   (CNT_W'(i)),
         .t      (t_n),
         .k      (CNT_W'(k_q)),
         .data   (a_data_o[i*DATA_WIDTH +: DATA_WIDTH]),
         .valid  (a_valid_o[i])
      );
      matmul_skew_lane #(.DW(DATA_WIDTH), .NUM(MAX_DIM), .CW(CNT_W)) u_b_lane (
         .clk    (clk_i),
         .rst_n  (rst_ni),
         .en     (!stall_i),
         .active ((nxt_state == ST_STREAM) && (DIM_W'(i) < m_q)),
         .vec    (b_col[i]),
         .lane   (CNT_W'(i)),
         .t      (t_n),
         .k      (CNT_W'(k_q)),
         .data   (b_data_o[i*DATA_WIDTH +: DATA_WIDTH]),
         .valid  (b_valid_o[i])
      );
   end

endmodule
